// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: latches a value, shows it as hex or decimal
// (sequential double-dabble), with leading-zero blanking, dp, blink and overflow dash.
//
// state  | meaning
// S_IDLE | display stable, loads accepted
// S_CONV | double-dabble conversion running, loads ignored
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      mode,
  input  logic                      lzb_en,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic                      busy,
  output logic                      ovf,
  output logic [7*NUM_DIGITS-1:0]   seg_n,
  output logic [NUM_DIGITS-1:0]     dp_n
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int BW = 4 * (NUM_DIGITS + 2);
  localparam int CW = $clog2(W + 1);
  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [0:0]              state_q, state_d;
  logic [W-1:0]            sreg_q, sreg_d;
  logic [BW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            disp_q, disp_d;
  logic                    lzb_q, lzb_d;
  logic                    lzb_pend_q, lzb_pend_d;
  logic                    ovf_q, ovf_d;
  logic [DW-1:0]           blk_cnt_q, blk_cnt_d;
  logic                    phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [BW-1:0]           acc_step;
  logic                    upper_zero;
  logic [3:0]              nib;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0010000;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110;
      4'hD: enc = 7'b0100001;
      4'hE: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int j = 0; j < NUM_DIGITS + 2; j++) begin
      if (a[4*j +: 4] >= 4'd5) r[4*j +: 4] = a[4*j +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    lzb_d      = lzb_q;
    lzb_pend_d = lzb_pend_q;
    ovf_d      = ovf_q;
    acc_step   = (add3(acc_q) << 1) | BW'(sreg_q[W-1]);
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (mode) begin
            state_d    = S_CONV;
            sreg_d     = data;
            acc_d      = '0;
            cnt_d      = '0;
            lzb_pend_d = lzb_en;
          end else begin
            disp_d = data;
            lzb_d  = lzb_en;
            ovf_d  = 1'b0;
          end
        end
      end
      default: begin
        acc_d  = acc_step;
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q + CW'(1);
        // Last step commits straight from the combinational result.
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_IDLE;
          disp_d  = acc_step[W-1:0];
          ovf_d   = |acc_step[BW-1:W];
          lzb_d   = lzb_pend_q;
        end
      end
    endcase
  end

  always_comb begin
    if (blk_cnt_q == DW'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + DW'(1);
      phase_d   = phase_q;
    end
  end

  // Scan from the top digit down so upper_zero covers digits i..NUM_DIGITS-1.
  always_comb begin
    seg_d      = '1;
    dp_d       = '1;
    upper_zero = 1'b1;
    nib        = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib        = disp_q[4*i +: 4];
      upper_zero = upper_zero & (nib == 4'd0);
      if (blink_mask[i] && phase_q) begin
        seg_d[7*i +: 7] = SEG_BLANK;
        dp_d[i]         = 1'b1;
      end else begin
        dp_d[i] = ~dp_in[i];
        if (ovf_q)                           seg_d[7*i +: 7] = SEG_DASH;
        else if (lzb_q && i > 0 && upper_zero) seg_d[7*i +: 7] = SEG_BLANK;
        else                                 seg_d[7*i +: 7] = enc(nib);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      lzb_q      <= 1'b0;
      lzb_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      blk_cnt_q  <= '0;
      phase_q    <= 1'b0;
      seg_q      <= '1;
      dp_q       <= '1;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      lzb_q      <= lzb_d;
      lzb_pend_q <= lzb_pend_d;
      ovf_q      <= ovf_d;
      blk_cnt_q  <= blk_cnt_d;
      phase_q    <= phase_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign busy  = (state_q == S_CONV);
  assign ovf   = ovf_q;
  assign seg_n = seg_q;
  assign dp_n  = dp_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: arithmetic reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_hex_display_ctrl;

  localparam int ND = 8;
  localparam int BD = 4;
  localparam int W  = 4 * ND;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          mode = 1'b0;
  logic          lzb_en = 1'b0;
  logic [W-1:0]  data = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] blink_mask = '0;
  logic          busy, ovf;
  logic [7*ND-1:0] seg_n;
  logic [ND-1:0] dp_n;

  int checks = 0;
  int errors = 0;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .lzb_en(lzb_en),
    .data(data), .dp_in(dp_in), .blink_mask(blink_mask),
    .busy(busy), .ovf(ovf), .seg_n(seg_n), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110 };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] ZERO  = 7'b1000000;

  // Model state
  int         ncyc = 0;
  int         m_busy = 0;
  logic [W-1:0] m_disp = '0, p_disp = '0;
  logic       m_lzb = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0, p_lzb = 1'b0;
  logic [7*ND-1:0] exp_seg = '1;
  logic [ND-1:0]   exp_dp = '1;
  logic       exp_busy = 1'b0, exp_ovf = 1'b0;
  int         ph;

  function automatic void dec_model(input logic [W-1:0] v, output logic [W-1:0] d,
                                    output logic o);
    longint q;
    q = longint'(v);
    d = '0;
    for (int i = 0; i < ND; i++) begin
      d[4*i +: 4] = 4'(q % 10);
      q = q / 10;
    end
    o = (q != 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ncyc = 0; m_busy = 0; m_disp = '0; m_lzb = 1'b0; m_ovf = 1'b0;
      exp_seg = '1; exp_dp = '1; exp_busy = 1'b0; exp_ovf = 1'b0;
    end else begin
      ph = (ncyc / BD) % 2;
      for (int i = 0; i < ND; i++) begin
        if (blink_mask[i] && ph == 1) begin
          exp_seg[7*i +: 7] = BLANK;
          exp_dp[i] = 1'b1;
        end else begin
          exp_dp[i] = ~dp_in[i];
          if (m_ovf) exp_seg[7*i +: 7] = DASH;
          else if (m_lzb && i > 0 && (m_disp >> (4*i)) == 0) exp_seg[7*i +: 7] = BLANK;
          else exp_seg[7*i +: 7] = seg_tab[m_disp[4*i +: 4]];
        end
      end
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          m_disp = p_disp; m_ovf = p_ovf; m_lzb = p_lzb;
        end
      end else if (load) begin
        if (mode) begin
          m_busy = W;
          dec_model(data, p_disp, p_ovf);
          p_lzb = lzb_en;
        end else begin
          m_disp = data; m_lzb = lzb_en; m_ovf = 1'b0;
        end
      end
      ncyc = ncyc + 1;
      exp_busy = (m_busy > 0);
      exp_ovf  = m_ovf;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (seg_n !== exp_seg) begin
      errors++; $display("FAIL seg_n t=%0t got %h exp %h", $time, seg_n, exp_seg);
    end
    checks++;
    if (dp_n !== exp_dp) begin
      errors++; $display("FAIL dp_n t=%0t got %h exp %h", $time, dp_n, exp_dp);
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++; $display("FAIL busy t=%0t got %b exp %b", $time, busy, exp_busy);
    end
    checks++;
    if (ovf !== exp_ovf) begin
      errors++; $display("FAIL ovf t=%0t got %b exp %b", $time, ovf, exp_ovf);
    end
  end

  task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic load_op(input logic m, input logic lz, input logic [W-1:0] d);
    @(posedge clk); #2;
    load = 1'b1; mode = m; lzb_en = lz; data = d;
    @(posedge clk); #2;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    bit done;
    done = 1'b0;
    for (n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_idle busy still %b after 200 cycles", busy);
    end
  endtask

  task automatic settle();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int bcnt;
    bit seen_low;
    int dp_low, d0_blank, steady_chg;
    logic [7*ND-1:8] upper_ref;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    settle();
    check_lit("zeros_after_reset", 64'(seg_n), 64'({8{ZERO}}));

    // Hex load of 0123ABCF
    load_op(1'b0, 1'b0, 32'h0123ABCF);
    settle();
    check_lit("hex_0123ABCF", 64'(seg_n),
      64'({ZERO, 7'b1111001, 7'b0100100, 7'b0110000,
           7'b0001000, 7'b0000011, 7'b1000110, 7'b0001110}));
    check_lit("hex_busy_low", 64'(busy), 64'd0);

    // Decimal 12345 with blanking; busy must last exactly W cycles
    load_op(1'b1, 1'b1, 32'd12345);
    bcnt = 0; seen_low = 1'b0;
    for (int n = 0; n < 100 && !seen_low; n++) begin
      @(negedge clk);
      if (busy) bcnt++; else seen_low = 1'b1;
    end
    check_lit("busy_len", 64'(bcnt), 64'd32);
    settle();
    check_lit("dec_12345", 64'(seg_n),
      64'({BLANK, BLANK, BLANK, 7'b1111001, 7'b0100100,
           7'b0110000, 7'b0011001, 7'b0010010}));
    check_lit("dec_12345_ovf", 64'(ovf), 64'd0);

    // Overflow then hex clear
    load_op(1'b1, 1'b0, 32'd100000000);
    wait_idle();
    settle();
    check_lit("ovf_set", 64'(ovf), 64'd1);
    check_lit("ovf_dashes", 64'(seg_n), 64'({8{DASH}}));
    load_op(1'b0, 1'b0, 32'd0);
    settle();
    check_lit("ovf_cleared", 64'(ovf), 64'd0);
    check_lit("hex_zero", 64'(seg_n), 64'({8{ZERO}}));

    // Blanked zero, then a load ignored mid-conversion
    load_op(1'b0, 1'b1, 32'd0);
    settle();
    check_lit("lzb_zero", 64'(seg_n), 64'({{7{BLANK}}, ZERO}));
    load_op(1'b1, 1'b0, 32'd987);
    repeat (5) @(posedge clk);
    load_op(1'b0, 1'b0, 32'h5);
    wait_idle();
    settle();
    check_lit("ignored_load", 64'(seg_n),
      64'({{5{ZERO}}, 7'b0010000, 7'b0000000, 7'b1111000}));

    // Blink digit 0 with dp
    @(posedge clk); #2 blink_mask = 8'h01; dp_in = 8'h01;
    settle();
    upper_ref = seg_n[7*ND-1:8];
    dp_low = 0; d0_blank = 0; steady_chg = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (dp_n[0] == 1'b0) dp_low++;
      if (seg_n[6:0] == BLANK) d0_blank++;
      if (seg_n[7*ND-1:8] != upper_ref || dp_n[ND-1:1] != '1) steady_chg++;
    end
    check_lit("blink_dp_low", 64'(dp_low), 64'd4);
    check_lit("blink_d0_blank", 64'(d0_blank), 64'd4);
    check_lit("blink_others_steady", 64'(steady_chg), 64'd0);
    @(posedge clk); #2 blink_mask = '0; dp_in = '0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #2;
      load   = ($urandom_range(0, 3) == 0);
      mode   = 1'($urandom);
      lzb_en = 1'($urandom);
      case ($urandom_range(0, 3))
        0: data = $urandom;
        1: data = $urandom_range(0, 99999999);
        2: data = $urandom_range(0, 999);
        default: data = '0;
      endcase
      dp_in      = 8'($urandom);
      blink_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    end
    @(posedge clk); #2 load = 1'b0; blink_mask = '0; dp_in = '0;
    wait_idle();

    // Reset in the middle of a conversion
    load_op(1'b0, 1'b0, 32'd0);
    load_op(1'b1, 1'b0, 32'd12345678);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_lit("rst_busy", 64'(busy), 64'd0);
    check_lit("rst_seg", 64'(seg_n), 64'({7*ND{1'b1}}));
    check_lit("rst_dp", 64'(dp_n), 64'({ND{1'b1}}));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    settle();
    check_lit("post_rst_zero", 64'(seg_n), 64'({8{ZERO}}));
    repeat (40) @(negedge clk);
    check_lit("aborted_never_shown", 64'(seg_n), 64'({8{ZERO}}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
